// File: rtl/noc_switch_allocator_if.sv
// Flit handshake bundle between the router input buffers, the switch
// allocator and the output crossbar. The master side drives flits in and
// sinks the allocator's decisions; the slave side is the allocator.
interface noc_switch_allocator_if #(
    parameter int NUM_PORTS   = 5,
    parameter int ROUTE_WIDTH = 3,
    parameter int DEST_WIDTH  = 2
);
    logic [NUM_PORTS-1:0]             in_valid;
    logic [NUM_PORTS-1:0]             in_head;
    logic [NUM_PORTS-1:0]             in_tail;
    logic [NUM_PORTS*DEST_WIDTH-1:0]  in_dest;
    logic [NUM_PORTS-1:0]             in_ready;
    logic [NUM_PORTS-1:0]             out_ready;
    logic [NUM_PORTS-1:0]             out_valid;
    logic [NUM_PORTS*ROUTE_WIDTH-1:0] out_sel;

    modport master (
        output in_valid, in_head, in_tail, in_dest, out_ready,
        input  in_ready, out_valid, out_sel
    );

    modport slave (
        input  in_valid, in_head, in_tail, in_dest, out_ready,
        output in_ready, out_valid, out_sel
    );
endinterface

// File: rtl/noc_switch_allocator.sv
// Wormhole switch allocator for one mesh router.
// Each output owns a small IDLE/LOCKED FSM, an owner register and a
// round-robin pointer. Head flits look up their output in the routing table;
// the output is held by its owner until the tail flit transfers.
//
// state     | meaning
// ST_IDLE   | output free, arbitrating among requesting head flits
// ST_LOCKED | output bound to owner_q, flits pass while out_ready is high
module noc_switch_allocator #(
    parameter int NUM_PORTS         = 5,
    parameter int NOC_NUM_ENDPOINTS = 4,
    parameter int ROUTE_WIDTH       = 3,
    parameter int DEST_WIDTH        = $clog2(NOC_NUM_ENDPOINTS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NOC_NUM_ENDPOINTS*ROUTE_WIDTH-1:0] routing_table,
    noc_switch_allocator_if.slave                 bus,
    output logic                                  route_err
);
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                 state_q  [NUM_PORTS];
    state_e                 state_d  [NUM_PORTS];
    logic [ROUTE_WIDTH-1:0] owner_q  [NUM_PORTS];
    logic [ROUTE_WIDTH-1:0] owner_d  [NUM_PORTS];
    logic [ROUTE_WIDTH-1:0] rr_ptr_q [NUM_PORTS];
    logic [ROUTE_WIDTH-1:0] rr_ptr_d [NUM_PORTS];
    logic                   route_err_q;
    logic                   route_err_d;

    logic [ROUTE_WIDTH-1:0] route    [NUM_PORTS];
    logic [NUM_PORTS-1:0]   route_ok;
    logic [NUM_PORTS-1:0]   is_owner;
    logic [NUM_PORTS-1:0]   head_req;
    logic [NUM_PORTS-1:0]   req      [NUM_PORTS];
    logic [NUM_PORTS-1:0]   own_valid;
    logic [NUM_PORTS-1:0]   own_tail;
    logic [NUM_PORTS-1:0]   grant_found;

    // Route lookup per input and the per-output request matrix.
    always_comb begin
        route_ok = '0;
        is_owner = '0;
        head_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            route[i] = '0;
            req[i]   = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int e = 0; e < NOC_NUM_ENDPOINTS; e++) begin
                if (bus.in_dest[i*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(e)) begin
                    route[i] = routing_table[e*ROUTE_WIDTH +: ROUTE_WIDTH];
                end
            end
            route_ok[i] = (32'(route[i]) < 32'(NUM_PORTS));
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (state_q[o] == ST_LOCKED && owner_q[o] == ROUTE_WIDTH'(i)) begin
                    is_owner[i] = 1'b1;
                end
            end
            // An input that already owns an output never raises a new request.
            head_req[i] = bus.in_valid[i] & bus.in_head[i] & ~is_owner[i];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = head_req[i] & route_ok[i] & (route[i] == ROUTE_WIDTH'(o));
            end
        end
    end

    // Per-output FSM next state, round-robin grant and crossbar/handshake outputs.
    always_comb begin
        route_err_d   = route_err_q | (|(head_req & ~route_ok));
        bus.in_ready  = '0;
        bus.out_valid = '0;
        bus.out_sel   = '0;
        own_valid     = '0;
        own_tail      = '0;
        grant_found   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o]  = state_q[o];
            owner_d[o]  = owner_q[o];
            rr_ptr_d[o] = rr_ptr_q[o];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (owner_q[o] == ROUTE_WIDTH'(i)) begin
                    own_valid[o] = bus.in_valid[i];
                    own_tail[o]  = bus.in_tail[i];
                end
            end
            case (state_q[o])
                ST_IDLE: begin
                    // First requester at or after rr_ptr, wrapping around.
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (!grant_found[o] && req[o][i] &&
                                ((32'(rr_ptr_q[o]) + 32'(k)) % 32'(NUM_PORTS)) == 32'(i)) begin
                                grant_found[o] = 1'b1;
                                owner_d[o]     = ROUTE_WIDTH'(i);
                                state_d[o]     = ST_LOCKED;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    bus.out_valid[o]                         = own_valid[o];
                    bus.out_sel[o*ROUTE_WIDTH +: ROUTE_WIDTH] = owner_q[o];
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (owner_q[o] == ROUTE_WIDTH'(i)) begin
                            bus.in_ready[i] = bus.out_ready[o];
                        end
                    end
                    if (own_valid[o] && bus.out_ready[o] && own_tail[o]) begin
                        state_d[o]  = ST_IDLE;
                        rr_ptr_d[o] = (owner_q[o] == ROUTE_WIDTH'(NUM_PORTS - 1)) ?
                                      '0 : owner_q[o] + ROUTE_WIDTH'(1);
                    end
                end
                default: state_d[o] = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o]  <= ST_IDLE;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
            route_err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o]  <= state_d[o];
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
            end
            route_err_q <= route_err_d;
        end
    end

    assign route_err = route_err_q;
endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed bench for the switch allocator: one task per scenario, each
// stepping a per-cycle table of stimulus and hand-computed responses.
module tb_noc_switch_allocator;
    logic        clk;
    logic        rst_n;
    logic [11:0] routing_table;
    logic        route_err;
    int          vec_cnt;
    int          err_cnt;

    typedef struct {
        logic [4:0]  vld;
        logic [4:0]  hd;
        logic [4:0]  tl;
        logic [4:0]  ordy;
        logic        rst;
        logic [4:0]  ov;
        logic [4:0]  ir;
        logic [14:0] sel;
        logic        re;
    } vec_t;

    noc_switch_allocator_if #(.NUM_PORTS(5), .ROUTE_WIDTH(3), .DEST_WIDTH(2)) bus ();

    noc_switch_allocator #(
        .NUM_PORTS(5), .NOC_NUM_ENDPOINTS(4), .ROUTE_WIDTH(3), .DEST_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .routing_table(routing_table),
        .bus(bus),
        .route_err(route_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_head   = '0;
        bus.in_tail   = '0;
        bus.out_ready = '1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        vec_t v [3] = '{
            '{5'b11111, 5'b11111, 5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b11111, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0}
        };
        routing_table = 12'h000;
        bus.in_dest   = 10'h000;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = v[c].vld; bus.in_head = v[c].hd; bus.in_tail = v[c].tl;
            bus.out_ready = v[c].ordy; rst_n = v[c].rst;
            #1;
            vec_cnt++;
            if (bus.out_valid !== v[c].ov) begin err_cnt++; $display("FAIL reset c%0d out_valid: got %b want %b", c, bus.out_valid, v[c].ov); end
            vec_cnt++;
            if (bus.in_ready !== v[c].ir) begin err_cnt++; $display("FAIL reset c%0d in_ready: got %b want %b", c, bus.in_ready, v[c].ir); end
            vec_cnt++;
            if (bus.out_sel !== v[c].sel) begin err_cnt++; $display("FAIL reset c%0d out_sel: got %h want %h", c, bus.out_sel, v[c].sel); end
            vec_cnt++;
            if (route_err !== v[c].re) begin err_cnt++; $display("FAIL reset c%0d route_err: got %b want %b", c, route_err, v[c].re); end
            tick();
        end
    endtask

    // Input 1 sends a 3-flit packet to endpoint 3, which maps to output 2.
    task automatic test_single_packet();
        vec_t v [5] = '{
            '{5'b00010, 5'b00010, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00010, 5'b00010, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00010, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0}
        };
        apply_reset();
        routing_table = 12'h400;
        bus.in_dest   = 10'h00C;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = v[c].vld; bus.in_head = v[c].hd; bus.in_tail = v[c].tl;
            bus.out_ready = v[c].ordy; rst_n = v[c].rst;
            #1;
            vec_cnt++;
            if (bus.out_valid !== v[c].ov) begin err_cnt++; $display("FAIL single c%0d out_valid: got %b want %b", c, bus.out_valid, v[c].ov); end
            vec_cnt++;
            if (bus.in_ready !== v[c].ir) begin err_cnt++; $display("FAIL single c%0d in_ready: got %b want %b", c, bus.in_ready, v[c].ir); end
            vec_cnt++;
            if (bus.out_sel !== v[c].sel) begin err_cnt++; $display("FAIL single c%0d out_sel: got %h want %h", c, bus.out_sel, v[c].sel); end
            tick();
        end
    endtask

    // Inputs 1 and 3 compete for output 2; rotation must alternate 1,3,1,3.
    task automatic test_contention();
        vec_t v [11] = '{
            '{5'b01010, 5'b01010, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b01010, 5'b01010, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b01010, 5'b01000, 5'b00010, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b01010, 5'b01010, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b01010, 5'b01010, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b01000, 15'h00C0, 1'b0},
            '{5'b01010, 5'b00010, 5'b01000, 5'b11111, 1'b1, 5'b00100, 5'b01000, 15'h00C0, 1'b0},
            '{5'b01010, 5'b01010, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b01010, 5'b01010, 5'b00010, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b01000, 5'b01000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b01000, 5'b01000, 5'b01000, 5'b11111, 1'b1, 5'b00100, 5'b01000, 15'h00C0, 1'b0},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0}
        };
        apply_reset();
        routing_table = 12'h400;
        bus.in_dest   = 10'h0CC;
        for (int c = 0; c < 11; c++) begin
            bus.in_valid = v[c].vld; bus.in_head = v[c].hd; bus.in_tail = v[c].tl;
            bus.out_ready = v[c].ordy; rst_n = v[c].rst;
            #1;
            vec_cnt++;
            if (bus.out_valid !== v[c].ov) begin err_cnt++; $display("FAIL contention c%0d out_valid: got %b want %b", c, bus.out_valid, v[c].ov); end
            vec_cnt++;
            if (bus.in_ready !== v[c].ir) begin err_cnt++; $display("FAIL contention c%0d in_ready: got %b want %b", c, bus.in_ready, v[c].ir); end
            vec_cnt++;
            if (bus.out_sel !== v[c].sel) begin err_cnt++; $display("FAIL contention c%0d out_sel: got %h want %h", c, bus.out_sel, v[c].sel); end
            tick();
        end
    endtask

    // out_ready[2] drops for two cycles while input 1 holds output 2.
    task automatic test_backpressure();
        vec_t v [7] = '{
            '{5'b00010, 5'b00010, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00010, 5'b00010, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00000, 5'b11011, 1'b1, 5'b00100, 5'b00000, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00000, 5'b11011, 1'b1, 5'b00100, 5'b00000, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00010, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0}
        };
        apply_reset();
        routing_table = 12'h400;
        bus.in_dest   = 10'h00C;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = v[c].vld; bus.in_head = v[c].hd; bus.in_tail = v[c].tl;
            bus.out_ready = v[c].ordy; rst_n = v[c].rst;
            #1;
            vec_cnt++;
            if (bus.out_valid !== v[c].ov) begin err_cnt++; $display("FAIL backpressure c%0d out_valid: got %b want %b", c, bus.out_valid, v[c].ov); end
            vec_cnt++;
            if (bus.in_ready !== v[c].ir) begin err_cnt++; $display("FAIL backpressure c%0d in_ready: got %b want %b", c, bus.in_ready, v[c].ir); end
            vec_cnt++;
            if (bus.out_sel !== v[c].sel) begin err_cnt++; $display("FAIL backpressure c%0d out_sel: got %h want %h", c, bus.out_sel, v[c].sel); end
            tick();
        end
    endtask

    // Input 0 -> endpoint 0 -> port 3, input 4 -> endpoint 1 -> port 1, same cycle.
    task automatic test_parallel_grants();
        vec_t v [4] = '{
            '{5'b10001, 5'b10001, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b10001, 5'b10001, 5'b00000, 5'b11111, 1'b1, 5'b01010, 5'b10001, 15'h0020, 1'b0},
            '{5'b10001, 5'b00000, 5'b10001, 5'b11111, 1'b1, 5'b01010, 5'b10001, 15'h0020, 1'b0},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0}
        };
        apply_reset();
        routing_table = 12'h00B;
        bus.in_dest   = 10'h100;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = v[c].vld; bus.in_head = v[c].hd; bus.in_tail = v[c].tl;
            bus.out_ready = v[c].ordy; rst_n = v[c].rst;
            #1;
            vec_cnt++;
            if (bus.out_valid !== v[c].ov) begin err_cnt++; $display("FAIL parallel c%0d out_valid: got %b want %b", c, bus.out_valid, v[c].ov); end
            vec_cnt++;
            if (bus.in_ready !== v[c].ir) begin err_cnt++; $display("FAIL parallel c%0d in_ready: got %b want %b", c, bus.in_ready, v[c].ir); end
            vec_cnt++;
            if (bus.out_sel !== v[c].sel) begin err_cnt++; $display("FAIL parallel c%0d out_sel: got %h want %h", c, bus.out_sel, v[c].sel); end
            tick();
        end
    endtask

    // Entry 2 = 6 is out of range: input 2 stalls and route_err sticks until reset.
    // Input 0 (single flit to port 0) must be served normally alongside.
    task automatic test_invalid_route();
        vec_t v [6] = '{
            '{5'b00101, 5'b00101, 5'b00001, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00101, 5'b00101, 5'b00001, 5'b11111, 1'b1, 5'b00001, 5'b00001, 15'h0000, 1'b1},
            '{5'b00100, 5'b00100, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b1},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b1},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b00000, 15'h0000, 1'b1},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0}
        };
        apply_reset();
        routing_table = 12'h180;
        bus.in_dest   = 10'h020;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = v[c].vld; bus.in_head = v[c].hd; bus.in_tail = v[c].tl;
            bus.out_ready = v[c].ordy; rst_n = v[c].rst;
            #1;
            vec_cnt++;
            if (bus.out_valid !== v[c].ov) begin err_cnt++; $display("FAIL invalid_route c%0d out_valid: got %b want %b", c, bus.out_valid, v[c].ov); end
            vec_cnt++;
            if (bus.in_ready !== v[c].ir) begin err_cnt++; $display("FAIL invalid_route c%0d in_ready: got %b want %b", c, bus.in_ready, v[c].ir); end
            vec_cnt++;
            if (route_err !== v[c].re) begin err_cnt++; $display("FAIL invalid_route c%0d route_err: got %b want %b", c, route_err, v[c].re); end
            tick();
        end
    endtask

    // Reset after the second flit; the leftover body flit must stall, a new head works.
    task automatic test_reset_mid_packet();
        vec_t v [9] = '{
            '{5'b00010, 5'b00010, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00010, 5'b00010, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b00010, 15'h0040, 1'b0},
            '{5'b00010, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00010, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00010, 5'b00010, 5'b00010, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0},
            '{5'b00010, 5'b00010, 5'b00010, 5'b11111, 1'b1, 5'b00100, 5'b00010, 15'h0040, 1'b0},
            '{5'b00000, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b00000, 5'b00000, 15'h0000, 1'b0}
        };
        apply_reset();
        routing_table = 12'h400;
        bus.in_dest   = 10'h00C;
        for (int c = 0; c < 9; c++) begin
            bus.in_valid = v[c].vld; bus.in_head = v[c].hd; bus.in_tail = v[c].tl;
            bus.out_ready = v[c].ordy; rst_n = v[c].rst;
            #1;
            vec_cnt++;
            if (bus.out_valid !== v[c].ov) begin err_cnt++; $display("FAIL reset_mid c%0d out_valid: got %b want %b", c, bus.out_valid, v[c].ov); end
            vec_cnt++;
            if (bus.in_ready !== v[c].ir) begin err_cnt++; $display("FAIL reset_mid c%0d in_ready: got %b want %b", c, bus.in_ready, v[c].ir); end
            vec_cnt++;
            if (bus.out_sel !== v[c].sel) begin err_cnt++; $display("FAIL reset_mid c%0d out_sel: got %h want %h", c, bus.out_sel, v[c].sel); end
            tick();
        end
    endtask

    initial begin
        vec_cnt       = 0;
        err_cnt       = 0;
        rst_n         = 1'b0;
        routing_table = 12'h000;
        bus.in_valid  = '0;
        bus.in_head   = '0;
        bus.in_tail   = '0;
        bus.in_dest   = '0;
        bus.out_ready = '1;
        tick();
        test_reset();
        test_single_packet();
        test_contention();
        test_backpressure();
        test_parallel_grants();
        test_invalid_route();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
